rom_ctrl_scan_counter: RTL and testbench

ROM_CTRL_SCAN_COUNTER -- requirements
Module: rom_ctrl_scan_counter

---
 rtl/rom_ctrl_pkg.sv | 24 ++
 rtl/rom_ctrl_scan_counter.sv | 142 ++++++++++++++
 tb/tb_rom_ctrl_scan_counter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the ROM controller scan logic.
// Holds the scan FSM state encoding, the read-latency bound and a width helper.
// Pure declarations: no logic, no latency, no flow control.
package rom_ctrl_pkg;

   // Upper bound on the ROM read latency the scan counter can wait out.
   localparam int MaxReadLatency = 4;

   // Sparse state encoding: every pair of codes differs in at least 3 bits,
   // so a single upset can never turn one legal state into another.
   typedef enum logic [5:0] {
      StIdle = 6'b000111,
      StReq  = 6'b011011,
      StWait = 6'b101101,
      StHold = 6'b111000,
      StDone = 6'b000000
   } scan_state_e;

   // Address width needed to index 'value' words (never less than 1).
   function automatic int vbits(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/rom_ctrl_scan_counter.sv
// Purpose : walks every ROM word once (0..RomDepth-1), one outstanding read at a time.
// Latency : data_vld_o rises ReadLatency cycles after read_req_o; one word per ReadLatency+1 cycles.
// Backpressure: the presented word and its flags hold stable until data_rdy_i is seen high.
// Ports   : clk_i/rst_ni clock and async active-low reset; start_i scan request; done_o scan
//           complete; read_addr_o/read_req_o ROM read port; data_vld_o/data_rdy_i/data_addr_o/
//           data_last_nontop_o/data_top_o consumer side; err_o protocol violation pulse.

`ifndef ASSERT_INIT
`define ASSERT_INIT(name_, prop_) if (!(prop_)) begin : name_ $fatal(1, "illegal parameter"); end
`endif

module rom_ctrl_scan_counter
   import rom_ctrl_pkg::*;
#(
   parameter int  RomDepth     = 16,
   parameter int  RomTopCount  = 2,
   parameter int  ReadLatency  = 1,
   parameter bit  AutoStart    = 1'b1,
   parameter bit  AllowRestart = 1'b0,
   localparam int AW           = vbits(RomDepth)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   output logic          done_o,
   output logic [AW-1:0] read_addr_o,
   output logic          read_req_o,
   output logic          data_vld_o,
   input  logic          data_rdy_i,
   output logic [AW-1:0] data_addr_o,
   output logic          data_last_nontop_o,
   output logic          data_top_o,
   output logic          err_o
);

   `ASSERT_INIT(RomDepthLegal_A, (RomDepth >= 4) && (RomDepth <= 65536))
   `ASSERT_INIT(RomTopCountLegal_A, (RomTopCount >= 1) && (RomTopCount <= RomDepth - 2))
   `ASSERT_INIT(ReadLatencyLegal_A, (ReadLatency >= 1) && (ReadLatency <= MaxReadLatency))

   localparam logic [AW-1:0] LastAddr       = AW'(RomDepth - 1);
   localparam logic [AW-1:0] LastNonTopAddr = AW'(RomDepth - RomTopCount - 1);
   localparam logic [AW-1:0] TopStartAddr   = AW'(RomDepth - RomTopCount);
   // Wait runs ReadLatency-1 cycles; the counter is loaded with one less than that.
   localparam logic [1:0]    LatLoad        = (ReadLatency >= 2) ? 2'(ReadLatency - 2) : 2'd0;

   scan_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    lat_q, lat_d;
   logic          first_q;   // high only in the first cycle after reset
   logic          last_q;    // addr_q is the last non-top word
   logic          done_q;
   logic          err_q, err_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lat_d   = lat_q;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if ((AutoStart && first_q) || start_i) begin
               state_d = StReq;
               addr_d  = '0;
            end
         end
         StReq: begin
            err_d = start_i;
            if (ReadLatency == 1) begin
               state_d = StHold;
            end else begin
               state_d = StWait;
               lat_d   = LatLoad;
            end
         end
         StWait: begin
            err_d = start_i;
            if (lat_q == 2'd0) begin
               state_d = StHold;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         StHold: begin
            err_d = start_i;
            if (data_rdy_i) begin
               if (addr_q == LastAddr) begin
                  state_d = StDone;
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = StReq;
               end
            end
         end
         StDone: begin
            if (start_i) begin
               if (AllowRestart) begin
                  state_d = StReq;
                  addr_d  = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            // Corrupted state register: park in Done and flag it.
            state_d = StDone;
            err_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         lat_q   <= 2'd0;
         first_q <= 1'b1;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         first_q <= 1'b0;
         // Tracks the address register so the flag needs no comparator on the output path.
         last_q  <= (addr_d == LastNonTopAddr);
         done_q  <= (state_d == StDone);
         err_q   <= err_d;
      end
   end

   assign read_addr_o        = addr_q;
   assign read_req_o         = (state_q == StReq);
   assign data_vld_o         = (state_q == StHold);
   assign data_addr_o        = addr_q;
   assign data_last_nontop_o = data_vld_o & last_q;
   assign data_top_o         = data_vld_o & (addr_q >= TopStartAddr);
   assign done_o             = done_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_rom_ctrl_scan_counter.sv
// Bench for rom_ctrl_scan_counter: four instances with different parameter sets,
// a transaction-timing reference model, a directed vector table and hand sequences.
// No flow control of its own; inputs change on the falling edge, outputs sampled there.
module tb_rom_ctrl_scan_counter;

   localparam int LAT   [4] = '{1, 3, 1, 2};
   localparam bit AUTO  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   localparam bit ALLOW [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   logic       clk_i = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] start_v = '0;
   logic [3:0] rdy_v = '1;
   logic [3:0] done_v, req_v, vld_v, last_v, top_v, err_v;
   logic [3:0] raddr_v [4];
   logic [3:0] daddr_v [4];

   always #5 clk_i = ~clk_i;

   rom_ctrl_scan_counter #(.ReadLatency(1), .AutoStart(1'b1), .AllowRestart(1'b0)) u_dut0 (
      .clk_i(clk_i), .rst_ni(rst_n), .start_i(start_v[0]), .done_o(done_v[0]),
      .read_addr_o(raddr_v[0]), .read_req_o(req_v[0]), .data_vld_o(vld_v[0]),
      .data_rdy_i(rdy_v[0]), .data_addr_o(daddr_v[0]), .data_last_nontop_o(last_v[0]),
      .data_top_o(top_v[0]), .err_o(err_v[0]));
   rom_ctrl_scan_counter #(.ReadLatency(3), .AutoStart(1'b1), .AllowRestart(1'b0)) u_dut1 (
      .clk_i(clk_i), .rst_ni(rst_n), .start_i(start_v[1]), .done_o(done_v[1]),
      .read_addr_o(raddr_v[1]), .read_req_o(req_v[1]), .data_vld_o(vld_v[1]),
      .data_rdy_i(rdy_v[1]), .data_addr_o(daddr_v[1]), .data_last_nontop_o(last_v[1]),
      .data_top_o(top_v[1]), .err_o(err_v[1]));
   rom_ctrl_scan_counter #(.ReadLatency(1), .AutoStart(1'b0), .AllowRestart(1'b0)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_n), .start_i(start_v[2]), .done_o(done_v[2]),
      .read_addr_o(raddr_v[2]), .read_req_o(req_v[2]), .data_vld_o(vld_v[2]),
      .data_rdy_i(rdy_v[2]), .data_addr_o(daddr_v[2]), .data_last_nontop_o(last_v[2]),
      .data_top_o(top_v[2]), .err_o(err_v[2]));
   rom_ctrl_scan_counter #(.ReadLatency(2), .AutoStart(1'b0), .AllowRestart(1'b1)) u_dut3 (
      .clk_i(clk_i), .rst_ni(rst_n), .start_i(start_v[3]), .done_o(done_v[3]),
      .read_addr_o(raddr_v[3]), .read_req_o(req_v[3]), .data_vld_o(vld_v[3]),
      .data_rdy_i(rdy_v[3]), .data_addr_o(daddr_v[3]), .data_last_nontop_o(last_v[3]),
      .data_top_o(top_v[3]), .err_o(err_v[3]));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: cycle count since reset release plus, per instance, the
   // word being scanned and the cycle its read was issued.
   int cyc;
   bit m_started [4];
   bit m_fin     [4];
   bit m_err     [4];
   int m_word    [4];
   int m_req_at  [4];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic bit busy(input int i);
      return m_started[i] && !m_fin[i] && (cyc >= m_req_at[i]);
   endfunction

   function automatic bit exp_vld(input int i);
      return busy(i) && (cyc >= m_req_at[i] + LAT[i]);
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         m_started[i] = AUTO[i];
         m_fin[i]     = 1'b0;
         m_err[i]     = 1'b0;
         m_word[i]    = 0;
         m_req_at[i]  = 1;
      end
   endtask

   // Consume this cycle's inputs and move the model to the next cycle.
   task automatic advance();
      for (int i = 0; i < 4; i++) begin
         bit nerr;
         nerr = 1'b0;
         if (!m_started[i]) begin
            if (start_v[i]) begin
               m_started[i] = 1'b1;
               m_word[i]    = 0;
               m_req_at[i]  = cyc + 1;
            end
         end else if (m_fin[i]) begin
            if (start_v[i]) begin
               if (ALLOW[i]) begin
                  m_fin[i]    = 1'b0;
                  m_word[i]   = 0;
                  m_req_at[i] = cyc + 1;
               end else begin
                  nerr = 1'b1;
               end
            end
         end else begin
            if (start_v[i] && busy(i)) nerr = 1'b1;
            if (exp_vld(i) && rdy_v[i]) begin
               if (m_word[i] == 15) m_fin[i] = 1'b1;
               else begin
                  m_word[i]   = m_word[i] + 1;
                  m_req_at[i] = cyc + 1;
               end
            end
         end
         m_err[i] = nerr;
      end
      cyc++;
   endtask

   task automatic check_inst(input int i);
      bit ev;
      ev = exp_vld(i);
      chk($sformatf("i%0d_req", i), int'(req_v[i]), int'(busy(i) && cyc == m_req_at[i]));
      chk($sformatf("i%0d_vld", i), int'(vld_v[i]), int'(ev));
      chk($sformatf("i%0d_raddr", i), int'(raddr_v[i]), m_word[i]);
      if (ev) chk($sformatf("i%0d_daddr", i), int'(daddr_v[i]), m_word[i]);
      chk($sformatf("i%0d_last", i), int'(last_v[i]), int'(ev && m_word[i] == 13));
      chk($sformatf("i%0d_top", i), int'(top_v[i]), int'(ev && m_word[i] >= 14));
      chk($sformatf("i%0d_done", i), int'(done_v[i]), int'(m_fin[i]));
      chk($sformatf("i%0d_err", i), int'(err_v[i]), int'(m_err[i]));
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) check_inst(i);
   endtask

   task automatic tick();
      advance();
      @(negedge clk_i);
      check_all();
   endtask

   // Assert reset mid-cycle, check outputs drop at once, release on a falling edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      for (int i = 0; i < 4; i++) chk($sformatf("i%0d_rst_daddr", i), int'(daddr_v[i]), 0);
      @(negedge clk_i);
      rst_n = 1'b1;
      #1 check_all();
   endtask

   typedef struct {
      bit       rdy;
      bit       start;
      bit       req;
      bit [3:0] raddr;
      bit       vld;
      bit [3:0] daddr;
      bit       last;
      bit       top;
      bit       done;
   } vec_t;

   vec_t tbl [36];

   initial begin
      // Default instance, consumer always ready: reads on odd cycles, words on even ones.
      for (int c = 0; c < 36; c++) begin
         int a;
         a = (c == 0) ? 0 : (((c - 1) / 2 > 15) ? 15 : (c - 1) / 2);
         tbl[c].rdy   = 1'b1;
         tbl[c].start = 1'b0;
         tbl[c].req   = (c % 2 == 1) && (c <= 31);
         tbl[c].vld   = (c % 2 == 0) && (c >= 2) && (c <= 32);
         tbl[c].raddr = 4'(a);
         tbl[c].daddr = 4'(a);
         tbl[c].last  = tbl[c].vld && (a == 13);
         tbl[c].top   = tbl[c].vld && (a >= 14);
         tbl[c].done  = (c >= 33);
      end

      // Phase 1: table run on instance 0, latency-3 timing on instance 1.
      do_reset();
      for (int c = 0; c < 36; c++) begin
         chk("tbl_req", int'(req_v[0]), int'(tbl[c].req));
         chk("tbl_raddr", int'(raddr_v[0]), int'(tbl[c].raddr));
         chk("tbl_vld", int'(vld_v[0]), int'(tbl[c].vld));
         if (tbl[c].vld) chk("tbl_daddr", int'(daddr_v[0]), int'(tbl[c].daddr));
         chk("tbl_last", int'(last_v[0]), int'(tbl[c].last));
         chk("tbl_top", int'(top_v[0]), int'(tbl[c].top));
         chk("tbl_done", int'(done_v[0]), int'(tbl[c].done));
         rdy_v[0]   = tbl[c].rdy;
         start_v[0] = tbl[c].start;
         tick();
      end
      while (cyc < 64) tick();
      chk("rl3_done_at64", int'(done_v[1]), 0);
      tick();
      chk("rl3_done_at65", int'(done_v[1]), 1);

      // Phase 2: backpressure at word 7 on instance 0.
      do_reset();
      for (int k = 0; k < 40 && !(vld_v[0] && daddr_v[0] == 4'd7); k++) tick();
      chk("bp_reach7", int'(vld_v[0] && daddr_v[0] == 4'd7), 1);
      for (int k = 0; k < 5; k++) begin
         rdy_v[0] = 1'b0;
         tick();
         chk("bp_vld_hold", int'(vld_v[0]), 1);
         chk("bp_addr_hold", int'(daddr_v[0]), 7);
         chk("bp_no_req", int'(req_v[0]), 0);
      end
      rdy_v[0] = 1'b1;
      tick();
      chk("bp_next_req", int'(req_v[0] && raddr_v[0] == 4'd8), 1);
      chk("auto0_idle", int'(req_v[2] | vld_v[2] | done_v[2]), 0);

      // Phase 3: manual start, stray start at word 4 on instance 2.
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      chk("man_no_req", int'(req_v[2] | req_v[3]), 0);
      start_v[2] = 1'b1;
      start_v[3] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      start_v[3] = 1'b0;
      chk("man_first_req", int'(req_v[2] && raddr_v[2] == 4'd0), 1);
      for (int k = 0; k < 30 && !(req_v[2] && raddr_v[2] == 4'd4); k++) tick();
      chk("man_reach4", int'(req_v[2] && raddr_v[2] == 4'd4), 1);
      start_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      chk("stray_err", int'(err_v[2]), 1);
      chk("stray_vld4", int'(vld_v[2] && daddr_v[2] == 4'd4), 1);
      tick();
      chk("stray_err_clr", int'(err_v[2]), 0);
      for (int k = 0; k < 100 && !(done_v[2] && done_v[3]); k++) tick();
      chk("man_done", int'(done_v[2] && done_v[3]), 1);

      // Phase 4: start in Done, with and without restart permission.
      start_v[2] = 1'b1;
      start_v[3] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      start_v[3] = 1'b0;
      chk("norestart_err", int'(err_v[2]), 1);
      chk("norestart_done", int'(done_v[2]), 1);
      chk("restart_done_clr", int'(done_v[3]), 0);
      chk("restart_req0", int'(req_v[3] && raddr_v[3] == 4'd0), 1);
      for (int k = 0; k < 5; k++) tick();
      chk("norestart_done_stays", int'(done_v[2]), 1);

      // Phase 5: random ready and occasional start on all instances.
      do_reset();
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 4; i++) begin
            rdy_v[i]   = ($urandom_range(0, 3) != 0);
            start_v[i] = ($urandom_range(0, 19) == 0);
         end
         tick();
      end
      start_v = '0;
      rdy_v   = '1;

      // Phase 6: reset while instance 1 waits on word 9.
      do_reset();
      for (int k = 0; k < 60 && !(req_v[1] && raddr_v[1] == 4'd9); k++) tick();
      chk("rst_reach9", int'(req_v[1] && raddr_v[1] == 4'd9), 1);
      tick();
      chk("rst_in_wait", int'(req_v[1] | vld_v[1]), 0);
      do_reset();
      chk("rst_outputs_zero", int'({req_v[1], vld_v[1], done_v[1], err_v[1], last_v[1], top_v[1],
                                    raddr_v[1], daddr_v[1]}), 0);
      tick();
      chk("rst_restart0", int'(req_v[1] && raddr_v[1] == 4'd0), 1);
      for (int k = 0; k < 10; k++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
